// File: rtl/perf_mon_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package perf_mon_pkg;

  // Monitor FSM: wait for start, count, then hold results until cleared.
  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_RUN  = 2'd1,
    PM_DONE = 2'd2
  } pm_state_t;

  localparam int PM_NUM_EVENTS_DEF = 4;
  localparam int PM_CNT_W_DEF      = 32;

  // Width of the readout channel select.
  localparam int PM_SEL_W = 4;

endpackage

// File: rtl/perf_event_counter.sv
// One CNT_W event counter with synchronous clear, selectable
// saturate/wrap behaviour on overflow and a sticky overflow flag.
module perf_event_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             w_at_max;
  logic [CNT_W-1:0] w_next;

  assign w_at_max = &r_count;

  // Value after one increment: all-ones either sticks or rolls over to zero.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_next = r_count + CNT_W'(1);
    if (w_at_max) begin
      w_next = SATURATE ? '1 : '0;
    end
  end

  // Counter and sticky flag; clear has the same effect as reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i || clear_i) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (inc_i) begin
      r_count <= w_next;
      if (w_at_max) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign count_o    = r_count;
  assign overflow_o = r_ovf;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline event monitor: counts run cycles and per-channel hazard events
// while enabled, stops at a programmable cycle limit, and exposes one
// selected counter through a registered readout port.
module pipe_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_EVENTS = PM_NUM_EVENTS_DEF,
  parameter int CNT_W      = PM_CNT_W_DEF,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [NUM_EVENTS-1:0] en_mask_i,
  input  logic [CNT_W-1:0]      cycle_limit_i,
  input  logic [PM_SEL_W-1:0]   sel_i,
  output logic [CNT_W-1:0]      count_o,
  output logic [CNT_W-1:0]      cycles_o,
  output logic [NUM_EVENTS-1:0] overflow_o,
  output logic                  running_o,
  output logic                  done_o
);

  pm_state_t        r_state;
  pm_state_t        w_state_next;
  logic             w_counted;
  logic             w_limit_hit;
  logic [CNT_W-1:0] w_cycles;
  logic [CNT_W-1:0] w_cycles_next;
  logic [CNT_W-1:0] w_ev_count [NUM_EVENTS];
  logic [CNT_W-1:0] w_sel_val;
  logic [CNT_W-1:0] r_count;

  // A cycle is counted only in RUN with the run enable high; otherwise paused.
  assign w_counted = (r_state == PM_RUN) && start_i;

  // Value the cycle counter takes on this counted cycle, used for the limit compare.
  always_comb begin
    w_cycles_next = w_cycles + CNT_W'(1);
    if (&w_cycles) begin
      w_cycles_next = SATURATE ? '1 : '0;
    end
  end

  // The limit is sampled live, so lowering it below the count stops on the next counted cycle.
  assign w_limit_hit = w_counted && (cycle_limit_i != '0) && (w_cycles_next >= cycle_limit_i);

  // FSM next state: clear overrides everything, DONE is left only by clear.
  always_comb begin
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = PM_IDLE;
    end else begin
      unique case (r_state)
        PM_IDLE: if (start_i)     w_state_next = PM_RUN;
        PM_RUN:  if (w_limit_hit) w_state_next = PM_DONE;
        PM_DONE: w_state_next = PM_DONE;
        default: w_state_next = PM_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= PM_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Cycle counter; its overflow flag has no consumer.
  perf_event_counter #(
    .CNT_W    (CNT_W),
    .SATURATE (SATURATE)
  ) u_cycle_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .inc_i      (w_counted),
    .count_o    (w_cycles),
    .overflow_o ()
  );

  // One counter per event channel, gated by its mask bit.
  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_evt
    perf_event_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_evt_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .inc_i      (w_counted && event_i[k] && en_mask_i[k]),
      .count_o    (w_ev_count[k]),
      .overflow_o (overflow_o[k])
    );
  end

  // Readout select: channels that do not exist read as zero.
  always_comb begin
    w_sel_val = '0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      if (sel_i == PM_SEL_W'(k)) begin
        w_sel_val = w_ev_count[k];
      end
    end
  end

  // Readout register, zeroed with the counters on clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_sel_val;
    end
  end

  assign count_o   = r_count;
  assign cycles_o  = w_cycles;
  assign running_o = (r_state == PM_RUN);
  assign done_o    = (r_state == PM_DONE);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor: directed sequences for the
// multi-cycle corner cases, a table of readout selects, and a randomized
// phase compared against a behavioural model of the 32-bit instance.
module tb_pipe_perf_monitor;

  localparam int NE = 4;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [NE-1:0] ev = '0;
  logic [NE-1:0] mask = '1;
  logic [31:0]   lim32 = '0;
  logic [3:0]    lim4 = '0;
  logic [3:0]    sel = '0;

  logic [31:0]   m_count, m_cycles;
  logic [NE-1:0] m_ovf;
  logic          m_running, m_done;
  logic [3:0]    s_count, s_cycles, w_count, w_cycles;
  logic [NE-1:0] s_ovf, w_ovf;
  logic          s_running, s_done, w_running, w_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.NUM_EVENTS(NE), .CNT_W(32), .SATURATE(1'b1)) u_main (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .en_mask_i(mask), .cycle_limit_i(lim32), .sel_i(sel), .count_o(m_count),
    .cycles_o(m_cycles), .overflow_o(m_ovf), .running_o(m_running), .done_o(m_done));

  pipe_perf_monitor #(.NUM_EVENTS(NE), .CNT_W(4), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .en_mask_i(mask), .cycle_limit_i(lim4), .sel_i(sel), .count_o(s_count),
    .cycles_o(s_cycles), .overflow_o(s_ovf), .running_o(s_running), .done_o(s_done));

  pipe_perf_monitor #(.NUM_EVENTS(NE), .CNT_W(4), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .en_mask_i(mask), .cycle_limit_i(lim4), .sel_i(sel), .count_o(w_count),
    .cycles_o(w_cycles), .overflow_o(w_ovf), .running_o(w_running), .done_o(w_done));

  // Behavioural model of u_main: mode 0 = idle, 1 = running, 2 = finished.
  int     md_mode = 0;
  longint md_ev [NE];
  longint md_cyc = 0;
  logic [NE-1:0] md_ovf = '0;
  longint md_count = 0;

  initial for (int k = 0; k < NE; k++) md_ev[k] = 0;

  always @(posedge clk) begin
    longint readout;
    if (rst || clear) begin
      md_mode = 0;
      for (int k = 0; k < NE; k++) md_ev[k] = 0;
      md_cyc = 0;
      md_ovf = '0;
      md_count = 0;
    end else begin
      readout = (sel < NE) ? md_ev[sel] : 0;
      if (md_mode == 1 && start) begin
        for (int k = 0; k < NE; k++) begin
          if (ev[k] && mask[k]) begin
            if (md_ev[k] == MAX32) md_ovf[k] = 1'b1;
            else md_ev[k] = md_ev[k] + 1;
          end
        end
        if (md_cyc != MAX32) md_cyc = md_cyc + 1;
        if (lim32 != 0 && md_cyc >= longint'(lim32)) md_mode = 2;
      end else if (md_mode == 0 && start) begin
        md_mode = 1;
      end
      md_count = readout;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] exp_count;
  } sel_vec_t;

  sel_vec_t vecs [6];

  initial begin
    vecs[0] = '{sel: 4'd0,  exp_count: 32'd8};
    vecs[1] = '{sel: 4'd1,  exp_count: 32'd0};
    vecs[2] = '{sel: 4'd2,  exp_count: 32'd8};
    vecs[3] = '{sel: 4'd3,  exp_count: 32'd0};
    vecs[4] = '{sel: 4'd7,  exp_count: 32'd0};
    vecs[5] = '{sel: 4'd15, exp_count: 32'd0};

    // Reset state of all instances.
    tick(2);
    check("rst_count",   m_count, 0);
    check("rst_cycles",  m_cycles, 0);
    check("rst_ovf",     m_ovf, 0);
    check("rst_running", m_running, 0);
    check("rst_done",    m_done, 0);
    check("rst_small",   {s_count, s_cycles, w_count, w_cycles, s_ovf, w_ovf}, 0);

    // Limit 30, event 0 every third counted cycle.
    rst = 1'b0; lim32 = 32'd30; mask = '1; sel = 4'd0; start = 1'b1;
    tick();
    check("t1_running", m_running, 1);
    for (int i = 0; i < 30; i++) begin
      ev = (i % 3 == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    check("t1_done",   m_done, 1);
    check("t1_cycles", m_cycles, 30);
    ev = 4'b1111;
    tick(3);
    check("t1_count_frozen",  m_count, 10);
    check("t1_cycles_frozen", m_cycles, 30);
    check("t1_done_held",     m_done, 1);

    // Clear together with start while finished.
    ev = '0; lim32 = '0; clear = 1'b1; start = 1'b1;
    tick();
    check("t2_idle", {m_running, m_done}, 0);
    check("t2_zero", {m_count, m_cycles, m_ovf}, 0);
    clear = 1'b0;
    tick();
    check("t2_running", m_running, 1);

    // Unlimited run with pauses; channel 1 held high.
    ev = 4'b0010;
    for (int i = 0; i < 14; i++) begin
      start = (i < 5 || i >= 9);
      tick();
      check("t3_running", m_running, 1);
    end
    start = 1'b0; sel = 4'd1;
    tick();
    check("t3_cycles", m_cycles, 10);
    check("t3_ch1",    m_count, 10);

    // Mask 0101 with all events high, then the readout table.
    clear = 1'b1; ev = '0;
    tick();
    clear = 1'b0; start = 1'b1;
    tick();
    mask = 4'b0101; ev = 4'b1111;
    tick(8);
    start = 1'b0; ev = '0;
    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      tick();
      check($sformatf("t4_sel%0d", vecs[i].sel), m_count, vecs[i].exp_count);
    end
    check("t4_cycles", m_cycles, 8);

    // Limit lowered mid-run below the current count.
    mask = '1; clear = 1'b1;
    tick();
    clear = 1'b0; start = 1'b1; lim32 = 32'd100;
    tick();
    tick(12);
    check("t5_cycles12", m_cycles, 12);
    lim32 = 32'd5; start = 1'b0;
    tick();
    check("t5_paused", {m_running, m_done}, 2'b10);
    start = 1'b1;
    tick();
    check("t5_done",   m_done, 1);
    check("t5_cycles", m_cycles, 13);
    tick();
    check("t5_held",   m_cycles, 13);

    // 4-bit counters, saturating and wrapping.
    lim32 = '0; lim4 = '0; clear = 1'b1; start = 1'b0;
    tick();
    clear = 1'b0; start = 1'b1;
    tick();
    ev = 4'b0100;
    tick(20);
    start = 1'b0; ev = '0; sel = 4'd2;
    tick();
    check("sat_ch2",     s_count, 15);
    check("sat_ovf",     s_ovf, 4'b0100);
    check("sat_cycles",  s_cycles, 15);
    check("wrap_ch2",    w_count, 4);
    check("wrap_ovf",    w_ovf, 4'b0100);
    check("wrap_cycles", w_cycles, 4);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 400) == 0;
      clear = ($urandom % 60) == 0;
      start = ($urandom % 8) != 0;
      ev    = 4'($urandom);
      mask  = (($urandom % 4) == 0) ? 4'($urandom) : 4'hF;
      sel   = 4'($urandom);
      if (($urandom % 50) == 0) lim32 = (($urandom % 3) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
      tick();
      check("rnd_count",   m_count,   64'(md_count));
      check("rnd_cycles",  m_cycles,  64'(md_cyc));
      check("rnd_ovf",     m_ovf,     64'(md_ovf));
      check("rnd_running", m_running, 64'(md_mode == 1));
      check("rnd_done",    m_done,    64'(md_mode == 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Parametrised pipeline event monitor that sits beside the CPU core and replaces ad-hoc bench-side stall/flush counting with synthesizable hardware. It counts run cycles and up to `NUM_EVENTS` independent hazard events, such as stall, flush, load-use and branch-taken. Counting stops automatically at a programmable cycle limit. Results are exposed through a registered select/readout port, so benches and debug logic sample identical values.

## Interface
- `NUM_EVENTS`, 4: number of event channels, 1..16.
- `CNT_W`, 32: width of every event counter and of the cycle counter.
- `SATURATE`, 1: 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  run enable. Counting happens only in cycles where this is 1.
- `clear_i`  in  1  synchronous clear of all counters, flags and the FSM.
- `event_i`  in  NUM_EVENTS  per-cycle event strobes from the pipeline.
- `en_mask_i`  in  NUM_EVENTS  per-channel count enable.
- `cycle_limit_i`  in  CNT_W  stop after this many counted cycles. 0 = unlimited.
- `sel_i`  in  4  channel select for `count_o`.
- `count_o`  out  CNT_W  registered value of the selected event counter.
- `cycles_o`  out  CNT_W  counted-cycle register.
- `overflow_o`  out  NUM_EVENTS  sticky per-channel overflow flags.
- `running_o`  out  1  FSM is in RUN.
- `done_o`  out  1  FSM is in DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start_i` = 1.
  - RUN → DONE when a counted cycle makes `cycles_next >= cycle_limit_i` and `cycle_limit_i != 0`.
  - DONE → IDLE only on `clear_i`.
  - Any state → IDLE on `rst_i` or `clear_i`.
- Counted cycle: state is RUN and `start_i` = 1. When `start_i` = 0 in RUN, all counters hold and the FSM stays in RUN (pause).
- In a counted cycle, `cycles_o` increments by 1. Channel k increments when `event_i[k] & en_mask_i[k]`.
- Overflow, per channel and for the cycle counter:
  - Overflow means an increment from all-ones.
  - `SATURATE` = 1: the value stays all-ones.
  - `SATURATE` = 0: the value becomes 0.
  - In both modes, the channel's `overflow_o[k]` is set and holds until cleared.
  - Cycle-counter overflow has no flag. In wrap mode with a limit active, DONE is still reached via the `>=` compare.
- `cycle_limit_i` is sampled live every cycle. If it is lowered mid-run to at or below `cycles_o`, the next counted cycle enters DONE.
- In IDLE and DONE, counters hold their values.
- Priority: `rst_i` > `clear_i` > counting. If `clear_i` and `start_i` arrive together, the result is IDLE with zeroed counters, and RUN is entered on the following cycle if `start_i` is still 1.
- If an event occurs on the cycle that reaches the limit, that event is counted.
- `sel_i >= NUM_EVENTS` gives `count_o` = 0.

## Timing
- Reset values: all counters 0, `count_o` 0, `cycles_o` 0, `overflow_o` all 0, `running_o` 0, `done_o` 0, state IDLE.
- Counter updates are visible on the clock edge after the counted cycle.
- `count_o` has 2 cycles of latency from an event strobe: 1 to the counter, 1 to the readout register. It has 1 cycle of latency from a `sel_i` change.
- `running_o` and `done_o` are decoded from the state register with no extra latency.
- `done_o` rises on the same edge that writes the final `cycles_o` value, so `cycles_o` = limit when `done_o` first reads 1.

## Structure
- Package `perf_mon_pkg` holds:
  - the FSM state enum (`PM_IDLE`, `PM_RUN`, `PM_DONE`);
  - default values for `NUM_EVENTS` and `CNT_W`;
  - the `sel_i` width constant.
- Sub-module `perf_event_counter` is one CNT_W counter with inc/clear inputs, the `SATURATE` behaviour and a sticky overflow flag. It is instantiated NUM_EVENTS+1 times (events plus cycles; the cycle instance's overflow output is left unused).
- The top level holds the FSM, the counted-cycle qualifier, the limit compare and the readout mux register.

## Test plan
- Reset, then `start_i` = 1, limit 30, `event_i[0]` high every 3rd cycle, mask all-ones → `done_o` rises with `cycles_o` = 30; `count_o`(sel 0) = 10; counts are frozen afterwards.
- Limit 0, `start_i` toggled 1 for 5, 0 for 4, 1 for 5 cycles, `event_i[1]` held high → `cycles_o` = 10, channel 1 = 10, `running_o` stays 1 throughout.
- `CNT_W` = 4, `SATURATE` = 1, `event_i[2]` held for 20 counted cycles → channel 2 = 15, `overflow_o[2]` = 1. Repeat with `SATURATE` = 0 → channel 2 = 4, flag = 1.
- `en_mask_i` = 4'b0101 with all events high for 8 cycles → channels 0 and 2 = 8, channels 1 and 3 = 0. `sel_i` = 7 → `count_o` = 0.
- `clear_i` and `start_i` asserted together while in DONE → the next cycle shows IDLE with all values 0; the cycle after shows `running_o` = 1.
- Limit lowered from 100 to 5 while `cycles_o` = 12 → DONE after the next counted cycle with `cycles_o` = 13.
